// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory and decode handshake bundle for fetch_ctrl
interface fetch_ctrl_if #(
   parameter int PC_W = 8
) ();
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic            inst_valid;
   logic [31:0]     inst;
   logic [PC_W-1:0] inst_pc;
   logic            stall;
   logic            timeout_err;

   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc, timeout_err,
      input  imem_ack, imem_rdata, stall
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc, timeout_err,
      output imem_ack, imem_rdata, stall
   );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer owning the PC, with redirect and memory timeout
module fetch_ctrl #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              MAX_WAIT = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   fetch_ctrl_if.master    bus
);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, FETCH, OUT, ERR} state_t;

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PC_W-1:0]  inst_pc_q, inst_pc_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [31:0]      inst_q, inst_d;
   logic             inst_valid_q, inst_valid_d;
   logic             timeout_err_q, timeout_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         inst_pc_q     <= '0;
         wait_cnt_q    <= '0;
         inst_q        <= '0;
         inst_valid_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inst_pc_q     <= inst_pc_d;
         wait_cnt_q    <= wait_cnt_d;
         inst_q        <= inst_d;
         inst_valid_q  <= inst_valid_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Redirect outranks ack, stall and run in every live state.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inst_pc_d     = inst_pc_q;
      wait_cnt_d    = wait_cnt_q;
      inst_d        = inst_q;
      inst_valid_d  = inst_valid_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         IDLE: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end else if (run) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (redirect_valid) begin
               pc_d       = redirect_pc;
               wait_cnt_d = '0;
            end else if (bus.imem_ack) begin
               inst_d       = bus.imem_rdata;
               inst_pc_d    = pc_q;
               inst_valid_d = 1'b1;
               pc_d         = pc_q + PC_W'(1);
               wait_cnt_d   = '0;
               state_d      = OUT;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
               if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                  state_d       = ERR;
                  timeout_err_d = 1'b1;
               end
            end
         end
         OUT: begin
            if (redirect_valid) begin
               inst_valid_d = 1'b0;
               pc_d         = redirect_pc;
               state_d      = FETCH;
            end else if (!bus.stall) begin
               inst_valid_d = 1'b0;
               state_d      = run ? FETCH : IDLE;
            end
         end
         ERR: begin
            inst_valid_d  = 1'b0;
            timeout_err_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.imem_req    = (state_q == FETCH);
   assign bus.imem_addr   = pc_q;
   assign bus.inst_valid  = inst_valid_q;
   assign bus.inst        = inst_q;
   assign bus.inst_pc     = inst_pc_q;
   assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with an instruction-stream reference model
module tb_fetch_ctrl;
   logic       clk;
   logic       rst_n;
   logic       run;
   logic       redirect_valid;
   logic [7:0] redirect_pc;

   int total = 0;
   int bad   = 0;

   // memory responder controls
   int         mem_delay;
   int         cur_delay;
   int         wcnt;
   logic       mem_dead;
   logic       rand_delay;
   logic       spurious;
   logic       req_prev;
   logic [7:0] addr_prev;

   fetch_ctrl_if #(.PC_W(8)) bus ();

   fetch_ctrl #(.PC_W(8), .RESET_PC(8'h00), .MAX_WAIT(15)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .run            (run),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [7:0] a);
      return {a, ~a, a ^ 8'h5C, {a[3:0], a[7:4]} ^ 8'hC3};
   endfunction

   // Advance one clock, then let the memory model answer the request now on the bus.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (bus.imem_req && !mem_dead) begin
         if (req_prev && bus.imem_addr == addr_prev) begin
            wcnt++;
         end else begin
            wcnt = 0;
            cur_delay = rand_delay ? int'($urandom_range(0, 3)) : mem_delay;
         end
         bus.imem_ack   = (wcnt >= cur_delay);
         bus.imem_rdata = bus.imem_ack ? word(bus.imem_addr) : $urandom;
      end else begin
         wcnt = 0;
         bus.imem_ack   = spurious && ($urandom_range(0, 3) == 0);
         bus.imem_rdata = $urandom;
      end
      req_prev  = bus.imem_req;
      addr_prev = bus.imem_addr;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 8'h00;
      bus.stall = 1'b0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'h0;
      mem_delay = 0;
      mem_dead = 1'b0;
      rand_delay = 1'b0;
      spurious = 1'b0;
      req_prev = 1'b0;
      addr_prev = 8'h00;
      wcnt = 0;
      cur_delay = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic set_pc(input logic [7:0] t);
      redirect_valid = 1'b1;
      redirect_pc = t;
      cyc();
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.inst_pc, bus.timeout_err} !== 51'h0) begin
         bad++;
         $display("FAIL reset_state: req=%b addr=%h v=%b inst=%h pc=%h err=%b want all zero",
                  bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.inst_pc, bus.timeout_err);
      end
   endtask

   task automatic test_stream();
      do_reset();
      run = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         total++;
         if ({bus.imem_req, bus.imem_addr, bus.inst_valid} !== {1'b1, 8'(k), 1'b0}) begin
            bad++;
            $display("FAIL stream_req%0d: req=%b addr=%h v=%b want 1 %h 0", k, bus.imem_req, bus.imem_addr, bus.inst_valid, 8'(k));
         end
         cyc();
         total++;
         if ({bus.inst_valid, bus.imem_req, bus.inst_pc, bus.inst} !== {2'b10, 8'(k), word(8'(k))}) begin
            bad++;
            $display("FAIL stream_inst%0d: v=%b req=%b pc=%h inst=%h want 1 0 %h %h",
                     k, bus.inst_valid, bus.imem_req, bus.inst_pc, bus.inst, 8'(k), word(8'(k)));
         end
      end
      run = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cyc();
         total++;
         if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin
            bad++;
            $display("FAIL stream_idle%0d: req=%b v=%b want 0 0", k, bus.imem_req, bus.inst_valid);
         end
      end
   endtask

   task automatic test_stall();
      int n_req;
      do_reset();
      set_pc(8'h05);
      mem_delay = 3;
      bus.stall = 1'b1;
      run = 1'b1;
      n_req = 0;
      for (int c = 0; c < 20; c++) begin
         cyc();
         if (bus.inst_valid) break;
         if (bus.imem_req) begin
            n_req++;
            total++;
            if (bus.imem_addr !== 8'h05) begin
               bad++;
               $display("FAIL stall_addr_stable: addr=%h want 05", bus.imem_addr);
            end
         end
      end
      total++;
      if (n_req !== 4) begin
         bad++;
         $display("FAIL stall_req_cycles: got %0d want 4", n_req);
      end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) cyc();
         total++;
         if ({bus.inst_valid, bus.imem_req, bus.inst_pc, bus.inst} !== {2'b10, 8'h05, word(8'h05)}) begin
            bad++;
            $display("FAIL stall_hold%0d: v=%b req=%b pc=%h inst=%h want 1 0 05 %h",
                     i, bus.inst_valid, bus.imem_req, bus.inst_pc, bus.inst, word(8'h05));
         end
      end
      bus.stall = 1'b0;
      cyc();
      total++;
      if ({bus.inst_valid, bus.imem_req, bus.imem_addr} !== {2'b01, 8'h06}) begin
         bad++;
         $display("FAIL stall_release: v=%b req=%b addr=%h want 0 1 06", bus.inst_valid, bus.imem_req, bus.imem_addr);
      end
      run = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus.inst_valid) break;
         cyc();
      end
      total++;
      if ({bus.inst_valid, bus.inst_pc} !== {1'b1, 8'h06}) begin
         bad++;
         $display("FAIL run_low_completes: v=%b pc=%h want 1 06", bus.inst_valid, bus.inst_pc);
      end
      cyc();
      cyc();
      total++;
      if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin
         bad++;
         $display("FAIL run_low_idle: req=%b v=%b want 0 0", bus.imem_req, bus.inst_valid);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_pc;
      int got;
      do_reset();
      set_pc(8'hFE);
      run = 1'b1;
      exp_pc = 8'hFE;
      got = 0;
      for (int c = 0; c < 40 && got < 4; c++) begin
         cyc();
         if (bus.inst_valid) begin
            total++;
            if ({bus.inst_pc, bus.inst} !== {exp_pc, word(exp_pc)}) begin
               bad++;
               $display("FAIL wrap_inst%0d: pc=%h inst=%h want %h %h", got, bus.inst_pc, bus.inst, exp_pc, word(exp_pc));
            end
            exp_pc++;
            got++;
         end
      end
      total++;
      if (got !== 4) begin
         bad++;
         $display("FAIL wrap_count: got %0d want 4", got);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      set_pc(8'h10);
      run = 1'b1;
      cyc();
      redirect_valid = 1'b1;
      redirect_pc = 8'h40;
      cyc();
      redirect_valid = 1'b0;
      total++;
      if ({bus.inst_valid, bus.imem_req, bus.imem_addr} !== {2'b01, 8'h40}) begin
         bad++;
         $display("FAIL redir_fetch: v=%b req=%b addr=%h want 0 1 40", bus.inst_valid, bus.imem_req, bus.imem_addr);
      end
      cyc();
      total++;
      if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 8'h40, word(8'h40)}) begin
         bad++;
         $display("FAIL redir_target_inst: v=%b pc=%h inst=%h want 1 40 %h", bus.inst_valid, bus.inst_pc, bus.inst, word(8'h40));
      end
      bus.stall = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 8'h20;
      cyc();
      redirect_valid = 1'b0;
      total++;
      if ({bus.inst_valid, bus.imem_req, bus.imem_addr} !== {2'b01, 8'h20}) begin
         bad++;
         $display("FAIL redir_flush: v=%b req=%b addr=%h want 0 1 20", bus.inst_valid, bus.imem_req, bus.imem_addr);
      end
      cyc();
      total++;
      if ({bus.inst_valid, bus.inst_pc} !== {1'b1, 8'h20}) begin
         bad++;
         $display("FAIL redir_resume: v=%b pc=%h want 1 20", bus.inst_valid, bus.inst_pc);
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      mem_dead = 1'b1;
      run = 1'b1;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         cyc();
         if (!bus.imem_req) break;
         n++;
         total++;
         if (bus.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: err=%b at req cycle %0d want 0", bus.timeout_err, n);
         end
      end
      total++;
      if (n !== 15 || bus.timeout_err !== 1'b1) begin
         bad++;
         $display("FAIL timeout_trip: req_cycles=%0d err=%b want 15 1", n, bus.timeout_err);
      end
      mem_dead = 1'b0;
      spurious = 1'b1;
      for (int c = 0; c < 10; c++) begin
         run = 1'($urandom_range(0, 1));
         redirect_valid = 1'($urandom_range(0, 1));
         redirect_pc = 8'($urandom);
         cyc();
         total++;
         if ({bus.timeout_err, bus.imem_req, bus.inst_valid} !== 3'b100) begin
            bad++;
            $display("FAIL timeout_sticky%0d: err=%b req=%b v=%b want 1 0 0", c, bus.timeout_err, bus.imem_req, bus.inst_valid);
         end
      end
      redirect_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.timeout_err !== 1'b0) begin
         bad++;
         $display("FAIL timeout_clear: err=%b want 0", bus.timeout_err);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_pc(8'h33);
      bus.stall = 1'b1;
      run = 1'b1;
      for (int c = 0; c < 10; c++) begin
         cyc();
         if (bus.inst_valid) break;
      end
      mem_dead = 1'b1;
      bus.stall = 1'b0;
      cyc();
      cyc();
      total++;
      if ({bus.imem_req, bus.imem_addr, bus.inst_pc} !== {1'b1, 8'h34, 8'h33}) begin
         bad++;
         $display("FAIL async_pre: req=%b addr=%h pc=%h want 1 34 33", bus.imem_req, bus.imem_addr, bus.inst_pc);
      end
      #3;
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.inst_pc, bus.timeout_err} !== 51'h0) begin
         bad++;
         $display("FAIL async_reset: req=%b addr=%h v=%b inst=%h pc=%h err=%b want all zero",
                  bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.inst_pc, bus.timeout_err);
      end
   endtask

   // Reference model tracks the instruction stream, not the controller's internal encoding.
   task automatic test_random();
      logic [7:0]  m_pc;
      logic [7:0]  m_ipc;
      logic [31:0] m_inst;
      logic        m_busy;
      logic        m_have;
      do_reset();
      rand_delay = 1'b1;
      spurious = 1'b1;
      m_pc = 8'h00;
      m_ipc = 8'h00;
      m_inst = 32'h0;
      m_busy = 1'b0;
      m_have = 1'b0;
      for (int c = 0; c < 400; c++) begin
         cyc();
         total++;
         if ({bus.imem_req, bus.imem_addr, bus.inst_valid} !== {m_busy, m_pc, m_have}) begin
            bad++;
            $display("FAIL rand_ctl@%0d: req=%b addr=%h v=%b want %b %h %b",
                     c, bus.imem_req, bus.imem_addr, bus.inst_valid, m_busy, m_pc, m_have);
         end
         if (m_have) begin
            total++;
            if ({bus.inst_pc, bus.inst} !== {m_ipc, m_inst}) begin
               bad++;
               $display("FAIL rand_inst@%0d: pc=%h inst=%h want %h %h", c, bus.inst_pc, bus.inst, m_ipc, m_inst);
            end
         end
         run = ($urandom_range(0, 99) < 85);
         bus.stall = 1'($urandom_range(0, 1));
         redirect_valid = ($urandom_range(0, 99) < 8);
         redirect_pc = 8'($urandom);
         if (redirect_valid) begin
            m_pc = redirect_pc;
            m_busy = m_busy || m_have;
            m_have = 1'b0;
         end else if (m_busy && bus.imem_ack) begin
            m_ipc = m_pc;
            m_inst = word(m_pc);
            m_pc = m_pc + 8'd1;
            m_have = 1'b1;
            m_busy = 1'b0;
         end else if (m_have && !bus.stall) begin
            m_have = 1'b0;
            m_busy = run;
         end else if (!m_busy && !m_have && run) begin
            m_busy = 1'b1;
         end
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_wrap();
      test_redirect();
      test_timeout();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
